sobel_window_gen: RTL
=====================

Name: sobel_window_gen

Overview:
- Upstream neighbour of the Sobel edge stage.
- Accepts a raster-order 8-bit grayscale pixel stream, one pixel per accepted beat, and buffers the two previous image rows.
- Emits one 3x3 neighbourhood window per interior pixel, so the Sobel stage computes directly on windows instead of storing the whole frame.
- Border pixels get no window; the downstream stage writes 0 at those positions.

Parameters:
- WIDTH, 640: image width in pixels; must be >= 3.
- DEPTH, 480: image height in rows; must be >= 3.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_sof  input  1  qualifies the current in_pixel as pixel (0,0) of a new frame
- in_valid  input  1  in_pixel/in_sof valid
- in_ready  output  1  block can accept a pixel this cycle
- in_pixel  input  8  grayscale pixel
- out_valid  output  1  out_window valid
- out_ready  input  1  downstream accepts the window
- out_window  output  72  3x3 window; byte k = out_window[8k+7:8k], k = 3*row+col, row 0 = top, col 0 = left
- frame_done  output  1  one-cycle pulse at frame end
- out_x  output  $clog2(WIDTH)  centre column (optional feature only)
- out_y  output  $clog2(DEPTH)  centre row (optional feature only)

Behaviour:
- Clocking and reset: one clock, clk; rst is synchronous and active-high.
- Reset values: out_valid=0, frame_done=0, out_window=0, counters=0, state=IDLE. Line-buffer contents are not reset.
- Accept condition: a pixel is accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready (combinational), so in_ready=1 after reset.
- State IDLE:
  - Accepted pixels without in_sof are dropped.
  - An accepted pixel with in_sof is stored as (0,0) and moves the block to ACTIVE with col=1, row=0.
- State ACTIVE:
  - Each accepted pixel at (c,r) is written to the current-row line buffer; the row written two rows earlier shifts to the top-row buffer.
  - col wraps at WIDTH-1 to 0 and increments row.
  - 3-column shift registers per row hold columns c-2 and c-1.
- Window emission:
  - Accepting pixel (c,r) with c>=2 and r>=2 registers the window centred at (c-1,r-1).
  - out_valid rises the next cycle, so latency is 1 cycle from accept.
  - Window rows: top = row r-2, middle = row r-1, bottom = row r.
  - Windows per frame: (WIDTH-2)*(DEPTH-2).
- Output hold: out_valid and out_window hold until out_ready; no window is lost or duplicated.
- Frame end:
  - Accepting pixel (WIDTH-1, DEPTH-1) moves the block to DONE.
  - frame_done pulses for one cycle, coincident with the final window's first out_valid cycle.
  - DONE returns to IDLE on the following cycle.
- in_sof while ACTIVE: aborts the current frame. The pixel becomes (0,0) of the new frame. No frame_done is issued. A pending registered window still completes its handshake.
- in_sof with a held output: if in_ready=0, in_sof is not accepted; upstream holds it.
- rst mid-frame: the window in flight is discarded and the block returns to IDLE on the next edge.
- Pixel arithmetic: none; pixel data passes through unmodified.
- Counter widths: $clog2 of WIDTH and of DEPTH.

Optional Feature:
- Macro: SOBEL_WIN_COORD_EN.
- Defined:
  - out_x/out_y ports exist.
  - They carry the centre coordinate (c-1, r-1), registered and held together with out_window.
  - Reset value 0.
- Undefined: the ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Package sobel_pkg:
  - pixel_t (8-bit logic).
  - WIN_PIXELS=9, WIN_BITS=72.
  - win_state_t enum {IDLE, ACTIVE, DONE}.
- Sub-module sobel_line_buffer:
  - Parameter WIDTH, 8-bit entries.
  - Write enable plus address, combinational read of the same address.
  - Instantiated twice (top row, middle row).
- Counters, shift registers, FSM and output register live in sobel_window_gen.

Test Plan (WIDTH=4, DEPTH=4, pixel value = raster index 0..15, out_ready=1 unless stated):
- Basic frame: in_sof on pixel 0, 16 back-to-back pixels
  - Exactly 4 windows, in order:
    - {0,1,2,4,5,6,8,9,10}
    - {1,2,3,5,6,7,9,10,11}
    - {4,5,6,8,9,10,12,13,14}
    - {5,6,7,9,10,11,13,14,15}
  - First out_valid 1 cycle after pixel 10 is accepted.
  - frame_done pulses once, with the last window.
- Backpressure: out_ready=0 for 5 cycles when the first window appears
  - in_ready=0 during the stall.
  - Window {0,1,2,4,5,6,8,9,10} is held stable.
  - Total windows still 4, with no duplicates.
- No sof: 16 pixels without in_sof
  - All dropped, out_valid never asserted, frame_done never asserted.
- Mid-frame restart: in_sof reasserted at pixel index 6 with values restarting at 0
  - The aborted frame yields no frame_done.
  - The new frame produces the 4 windows of the basic-frame test.
- Reset mid-frame: rst for 1 cycle after pixel 11
  - out_valid=0 the next cycle.
  - A following full frame produces the correct 4 windows.
- SOBEL_WIN_COORD_EN defined, basic frame
  - out_x/out_y sequence is (1,1), (2,1), (1,2), (2,2).

Source files
------------

// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared types and constants for the Sobel 3x3 window generator
package sobel_pkg;

  typedef logic [7:0] pixel_t;

  localparam int WIN_PIXELS = 9;
  localparam int WIN_BITS   = 72;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } win_state_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// rtl/sobel_line_buffer.sv - one image row of pixel storage, write and read at the same column address
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int WIDTH = 640
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(WIDTH)-1:0] addr,
  input  pixel_t                   wdata,
  output pixel_t                   rdata
);

  pixel_t mem [WIDTH];

  // Storage is deliberately not reset; every entry is rewritten before it is read for a window.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // The old value at this column is visible before the write lands, so it can shift upward.
  assign rdata = mem[addr];

endmodule

// File: rtl/sobel_window_gen.sv
// rtl/sobel_window_gen.sv - raster pixel stream to 3x3 interior windows; optional SOBEL_WIN_COORD_EN adds out_x/out_y
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int WIDTH = 640,
  parameter int DEPTH = 480
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_sof,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_pixel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIN_BITS-1:0] out_window,
  output logic                frame_done
`ifdef SOBEL_WIN_COORD_EN
  ,
  output logic [$clog2(WIDTH)-1:0] out_x,
  output logic [$clog2(DEPTH)-1:0] out_y
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(DEPTH);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(DEPTH - 1);

  win_state_t state, state_nxt;

  logic [CW-1:0] col, cur_c;
  logic [RW-1:0] row, cur_r;
  logic          accept, take, emit, last_px;

  pixel_t top_rd, mid_rd;
  pixel_t t1, t2, m1, m2, b1, b2;
  logic [WIN_BITS-1:0] win_nxt;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // A start-of-frame beat always lands at (0,0); otherwise only ACTIVE frames take pixels.
  assign take    = accept && (in_sof || state == ACTIVE);
  assign cur_c   = in_sof ? '0 : col;
  assign cur_r   = in_sof ? '0 : row;
  assign emit    = take && (cur_c >= CW'(2)) && (cur_r >= RW'(2));
  assign last_px = take && (cur_c == COL_LAST) && (cur_r == ROW_LAST);

  // DONE lasts exactly the one cycle in which the final window first shows valid.
  assign frame_done = (state == DONE);

  // Byte k = 3*row + col, so the oldest top-row pixel sits in the least significant byte.
  assign win_nxt = {in_pixel, b1, b2, mid_rd, m1, m2, top_rd, t1, t2};

  sobel_line_buffer #(.WIDTH(WIDTH)) u_top_row (
    .clk   (clk),
    .we    (take),
    .addr  (cur_c),
    .wdata (mid_rd),
    .rdata (top_rd)
  );

  sobel_line_buffer #(.WIDTH(WIDTH)) u_mid_row (
    .clk   (clk),
    .we    (take),
    .addr  (cur_c),
    .wdata (in_pixel),
    .rdata (mid_rd)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Frame sequencing: start on sof, finish on the bottom-right pixel, restart on any later sof.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = ACTIVE;
      ACTIVE:  if (last_px) state_nxt = DONE;
      DONE:    state_nxt = take ? ACTIVE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Raster position of the next pixel expected in the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (take) begin
      if (last_px) begin
        col <= '0;
        row <= '0;
      end else if (cur_c == COL_LAST) begin
        col <= '0;
        row <= cur_r + RW'(1);
      end else begin
        col <= cur_c + CW'(1);
        row <= cur_r;
      end
    end
  end

  // Per-row history of columns c-1 and c-2; stale data at row starts is never emitted.
  always_ff @(posedge clk) begin
    if (take) begin
      t2 <= t1;
      t1 <= top_rd;
      m2 <= m1;
      m1 <= mid_rd;
      b2 <= b1;
      b1 <= in_pixel;
    end
  end

  // Output register: load on an interior pixel, hold until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_window <= '0;
`ifdef SOBEL_WIN_COORD_EN
      out_x      <= '0;
      out_y      <= '0;
`endif
    end else if (emit) begin
      out_valid  <= 1'b1;
      out_window <= win_nxt;
`ifdef SOBEL_WIN_COORD_EN
      out_x      <= cur_c - CW'(1);
      out_y      <= cur_r - RW'(1);
`endif
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
